// File: rtl/plot_arbiter.sv
// Shares the single VGA adapter write port between a full-screen clear engine and two
// player plot requesters. Clear always wins; the players alternate on ties.
//
// state   | meaning
// S_IDLE  | players arbitrate round-robin for the write port
// S_CLEAR | clear engine owns the port, one pixel per cycle in raster order
module plot_arbiter #(
   parameter int          SCREEN_W     = 160,
   parameter int          SCREEN_H     = 120,
   parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       clear_start,
   output logic       clear_busy,
   input  logic       p1_req,
   input  logic [7:0] p1_x,
   input  logic [6:0] p1_y,
   input  logic [2:0] p1_colour,
   output logic       p1_ack,
   input  logic       p2_req,
   input  logic [7:0] p2_x,
   input  logic [6:0] p2_y,
   input  logic [2:0] p2_colour,
   output logic       p2_ack,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       oob
);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   localparam logic [7:0] W_LAST = 8'(SCREEN_W - 1);
   localparam logic [6:0] H_LAST = 7'(SCREEN_H - 1);
   localparam logic [8:0] W_LIM  = 9'(SCREEN_W);
   localparam logic [7:0] H_LIM  = 8'(SCREEN_H);

   state_t     state, state_nxt;
   logic [7:0] cx, cx_nxt;
   logic [6:0] cy, cy_nxt;
   logic       last_grant, last_grant_nxt;   // 0 = P1, 1 = P2

   logic [7:0] x_nxt;
   logic [6:0] y_nxt;
   logic [2:0] colour_nxt;
   logic       plot_nxt, p1_ack_nxt, p2_ack_nxt, clear_busy_nxt, oob_nxt;

   // A start pulse plots (0,0) on the same edge, so the clear pixel is taken from the
   // restarted counters rather than the current ones.
   logic       clr_active;
   logic [7:0] clr_x;
   logic [6:0] clr_y;
   logic       elig1, elig2, grant1, grant2;
   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_colour;
   logic       sel_in_range;

   assign clr_active = clear_start || (state == S_CLEAR);
   assign clr_x      = clear_start ? 8'd0 : cx;
   assign clr_y      = clear_start ? 7'd0 : cy;

   // A requester is ineligible while its ack is high, so stale data is never granted twice.
   assign elig1  = p1_req && !p1_ack;
   assign elig2  = p2_req && !p2_ack;
   assign grant1 = !clr_active && elig1 && (!elig2 || last_grant);
   assign grant2 = !clr_active && elig2 && (!elig1 || !last_grant);

   assign sel_x        = grant1 ? p1_x : p2_x;
   assign sel_y        = grant1 ? p1_y : p2_y;
   assign sel_colour   = grant1 ? p1_colour : p2_colour;
   assign sel_in_range = ({1'b0, sel_x} < W_LIM) && ({1'b0, sel_y} < H_LIM);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         cx         <= 8'd0;
         cy         <= 7'd0;
         last_grant <= 1'b1;
         x          <= 8'd0;
         y          <= 7'd0;
         colour     <= 3'd0;
         plot       <= 1'b0;
         p1_ack     <= 1'b0;
         p2_ack     <= 1'b0;
         clear_busy <= 1'b0;
         oob        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cx         <= cx_nxt;
         cy         <= cy_nxt;
         last_grant <= last_grant_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
         colour     <= colour_nxt;
         plot       <= plot_nxt;
         p1_ack     <= p1_ack_nxt;
         p2_ack     <= p2_ack_nxt;
         clear_busy <= clear_busy_nxt;
         oob        <= oob_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cx_nxt    = cx;
      cy_nxt    = cy;
      if (clr_active) begin
         if (clr_x == W_LAST && clr_y == H_LAST) begin
            state_nxt = S_IDLE;
            cx_nxt    = 8'd0;
            cy_nxt    = 7'd0;
         end else begin
            state_nxt = S_CLEAR;
            if (clr_x == W_LAST) begin
               cx_nxt = 8'd0;
               cy_nxt = clr_y + 7'd1;
            end else begin
               cx_nxt = clr_x + 8'd1;
               cy_nxt = clr_y;
            end
         end
      end
   end

   always_comb begin
      x_nxt          = x;
      y_nxt          = y;
      colour_nxt     = colour;
      plot_nxt       = 1'b0;
      p1_ack_nxt     = 1'b0;
      p2_ack_nxt     = 1'b0;
      clear_busy_nxt = clr_active;
      oob_nxt        = oob;
      last_grant_nxt = last_grant;
      if (clr_active) begin
         x_nxt      = clr_x;
         y_nxt      = clr_y;
         colour_nxt = CLEAR_COLOUR;
         plot_nxt   = 1'b1;
      end else if (grant1 || grant2) begin
         p1_ack_nxt     = grant1;
         p2_ack_nxt     = grant2;
         last_grant_nxt = grant2;
         if (sel_in_range) begin
            x_nxt      = sel_x;
            y_nxt      = sel_y;
            colour_nxt = sel_colour;
            plot_nxt   = 1'b1;
         end else begin
            oob_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: clear engine, round-robin player grants,
// out-of-range drops, clear restart and reset priority.
module tb_plot_arbiter;

   logic       clk = 1'b0;
   logic       resetn, clear_start, clear_busy;
   logic       p1_req, p1_ack, p2_req, p2_ack;
   logic [7:0] p1_x, p2_x, x;
   logic [6:0] p1_y, p2_y, y;
   logic [2:0] p1_colour, p2_colour, colour;
   logic       plot, oob;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   plot_arbiter dut (
      .clk(clk), .resetn(resetn), .clear_start(clear_start), .clear_busy(clear_busy),
      .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y), .p1_colour(p1_colour), .p1_ack(p1_ack),
      .p2_req(p2_req), .p2_x(p2_x), .p2_y(p2_y), .p2_colour(p2_colour), .p2_ack(p2_ack),
      .x(x), .y(y), .colour(colour), .plot(plot), .oob(oob)
   );

   always #5 clk = ~clk;

   // Outputs packed as {plot, clear_busy, p1_ack, p2_ack, oob, x, y, colour}
   function automatic logic [22:0] pack(input logic pl, input logic cb, input logic a1,
                                        input logic a2, input logic ob, input logic [7:0] px,
                                        input logic [6:0] py, input logic [2:0] pc);
      return {pl, cb, a1, a2, ob, px, py, pc};
   endfunction

   task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic pl, input logic cb, input logic a1,
                            input logic a2, input logic ob, input logic [7:0] px,
                            input logic [6:0] py, input logic [2:0] pc);
      check(tag, pack(plot, clear_busy, p1_ack, p2_ack, oob, x, y, colour),
            pack(pl, cb, a1, a2, ob, px, py, pc));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; clear_start = 1'b0;
      p1_req = 1'b0; p1_x = 8'd0; p1_y = 7'd0; p1_colour = 3'd0;
      p2_req = 1'b0; p2_x = 8'd0; p2_y = 7'd0; p2_colour = 3'd0;
      tick(); tick();
      check_out("reset", 0, 0, 0, 0, 0, 8'd0, 7'd0, 3'd0);
      resetn = 1'b1;

      // Full clear: 19200 consecutive raster-order plots
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int i = 0; i < 19200; i++) begin
         if (i > 0) tick();
         check_out("clear_pixel", 1, 1, 0, 0, 0, 8'(i % 160), 7'(i / 160), 3'd0);
      end
      tick();
      check_out("clear_done", 0, 0, 0, 0, 0, 8'd159, 7'd119, 3'd0);

      // P1 alone: plot every other cycle, new data after each ack
      p1_req = 1'b1; p1_x = 8'd10; p1_y = 7'd20; p1_colour = 3'b100;
      for (int n = 0; n < 4; n++) begin
         tick();
         check_out("p1_grant", 1, 0, 1, 0, 0, 8'(10 + n), 7'd20, 3'b100);
         p1_x = 8'(11 + n);
         tick();
         check_out("p1_gap", 0, 0, 0, 0, 0, 8'(10 + n), 7'd20, 3'b100);
      end
      p1_req = 1'b0;
      tick();

      // Both players after reset: P1 first, then strict alternation
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      p1_req = 1'b1; p1_x = 8'd5; p1_y = 7'd5; p1_colour = 3'b001;
      p2_req = 1'b1; p2_x = 8'd7; p2_y = 7'd7; p2_colour = 3'b010;
      for (int n = 0; n < 3; n++) begin
         tick();
         check_out("rr_p1", 1, 0, 1, 0, 0, 8'd5, 7'd5, 3'b001);
         tick();
         check_out("rr_p2", 1, 0, 0, 1, 0, 8'd7, 7'd7, 3'b010);
      end
      p1_req = 1'b0; p2_req = 1'b0;
      tick();
      check_out("rr_idle", 0, 0, 0, 0, 0, 8'd7, 7'd7, 3'b010);

      // Out-of-range x is acked but dropped, oob sticks
      p2_req = 1'b1; p2_x = 8'd160; p2_y = 7'd0; p2_colour = 3'b111;
      tick();
      check_out("oob_x_drop", 0, 0, 0, 1, 1, 8'd7, 7'd7, 3'b010);
      p2_x = 8'd3; p2_y = 7'd4; p2_colour = 3'b101;
      tick();
      check_out("oob_gap", 0, 0, 0, 0, 1, 8'd7, 7'd7, 3'b010);
      tick();
      check_out("oob_then_ok", 1, 0, 0, 1, 1, 8'd3, 7'd4, 3'b101);
      p2_req = 1'b0;
      p1_req = 1'b1; p1_x = 8'd0; p1_y = 7'd120; p1_colour = 3'b001;
      tick();
      check_out("oob_y_drop", 0, 0, 1, 0, 1, 8'd3, 7'd4, 3'b101);
      p1_req = 1'b0;
      tick();

      // Clear beats a same-cycle request; restart at pixel 100; P1 waits throughout
      p1_req = 1'b1; p1_x = 8'd10; p1_y = 7'd20; p1_colour = 3'b100;
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      check_out("clear2_first", 1, 1, 0, 0, 1, 8'd0, 7'd0, 3'd0);
      for (int i = 1; i < 100; i++) begin
         tick();
         check_out("clear2_pre", 1, 1, 0, 0, 1, 8'(i % 160), 7'(i / 160), 3'd0);
      end
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int i = 0; i < 19200; i++) begin
         if (i > 0) tick();
         check_out("clear2_restart", 1, 1, 0, 0, 1, 8'(i % 160), 7'(i / 160), 3'd0);
      end
      tick();
      check_out("clear2_p1_after", 1, 0, 1, 0, 1, 8'd10, 7'd20, 3'b100);
      p1_req = 1'b0;
      tick();

      // Reset (with a simultaneous clear_start) aborts a clear at pixel 500
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      for (int i = 1; i <= 500; i++) tick();
      check_out("clear3_px500", 1, 1, 0, 0, 1, 8'd20, 7'd3, 3'd0);
      resetn = 1'b0; clear_start = 1'b1;
      tick();
      check_out("midclear_reset", 0, 0, 0, 0, 0, 8'd0, 7'd0, 3'd0);
      resetn = 1'b1; clear_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out("post_reset_idle", 0, 0, 0, 0, 0, 8'd0, 7'd0, 3'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Arbitrates the single `vga_adapter` write port (x/y/colour/plot) between a full-screen clear engine and two player trail-plot requesters. One pixel is written per cycle at most. Clear has absolute priority; the two players share the remaining slots round-robin. Sits between the player datapaths / game controller and the VGA adapter, driving `x`, `y`, `colour` and `writeEn` at the top level.

## Interface

Parameters:
- `SCREEN_W`, default 160: horizontal pixel count; valid x is 0..SCREEN_W-1.
- `SCREEN_H`, default 120: vertical pixel count; valid y is 0..SCREEN_H-1.
- `CLEAR_COLOUR`, default 3'b000: colour written by the clear engine.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  reset, synchronous and active-low.
- `clear_start`  in  1  single-cycle pulse that starts a full-screen clear.
- `clear_busy`  out  1  high while the clear engine owns the port.
- `p1_req`  in  1  player 1 plot request. Held until acknowledged.
- `p1_x`  in  8  player 1 pixel x.
- `p1_y`  in  7  player 1 pixel y.
- `p1_colour`  in  3  player 1 colour.
- `p1_ack`  out  1  single-cycle acknowledge to player 1.
- `p2_req`, `p2_x`, `p2_y`, `p2_colour`, `p2_ack`: same as above, for player 2.
- `x`  out  8  pixel x to the VGA adapter.
- `y`  out  7  pixel y to the VGA adapter.
- `colour`  out  3  pixel colour to the VGA adapter.
- `plot`  out  1  write enable to the VGA adapter.
- `oob`  out  1  sticky flag: an out-of-range request was dropped.

## Operation

- FSM states: S_IDLE and S_CLEAR. All outputs are registered.
- Reset (`resetn`=0 at an edge):
  - State goes to S_IDLE.
  - `x`=0, `y`=0, `colour`=0.
  - `plot`=0, `p1_ack`=0, `p2_ack`=0, `clear_busy`=0, `oob`=0.
  - `last_grant`=P2, so P1 wins the first tie.
  - Clear counters go to 0.
  - Reset aborts a clear in progress.
- `clear_start` sampled high in any state:
  - Go to S_CLEAR with cx=0, cy=0.
  - If already in S_CLEAR, restart from (0,0).
- S_CLEAR:
  - Each cycle, register `x`=cx, `y`=cy, `colour`=CLEAR_COLOUR, `plot`=1.
  - cx increments. When cx reaches SCREEN_W-1 it wraps to 0 and cy increments.
  - After plotting (SCREEN_W-1, SCREEN_H-1), return to S_IDLE.
  - No player acks are issued during a clear. Requests stay pending.
- S_IDLE arbitration, each cycle:
  - A requester is eligible if its `req` is high AND its `ack` is not high this cycle. This prevents re-granting stale data.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not `last_grant`.
  - On a grant:
    - Next cycle, `pN_ack`=1 for exactly one cycle.
    - `last_grant` is updated to that requester.
    - In range (x < SCREEN_W and y < SCREEN_H): register the requester's x/y/colour and set `plot`=1.
    - Out of range: set `plot`=0 and `oob`=1. `oob` stays 1 until reset. The ack is still given.
  - No grant: `plot`=0. `x`/`y`/`colour` hold their previous values.
- Requester rules:
  - Data must be stable while `req` is high.
  - After seeing `ack`, the requester may drop `req` or present new data at the next edge.

## Timing

- Grant latency: `req` sampled high at edge k (idle, eligible, won arbitration) gives `plot`/`ack` high in cycle k+1.
- Single-requester throughput: one plot per 2 cycles, because the requester is ineligible during its ack cycle.
- Two continuous requesters: grants alternate every cycle, so the port is 100% utilised.
- Clear duration: the clear edge gives `clear_busy`=1 and the first clear plot (0,0) in the next cycle. Exactly SCREEN_W×SCREEN_H = 19200 consecutive plot cycles follow.
  - `clear_busy` falls in the cycle after the last plot (159,119).
  - Player grants may begin in that same cycle, i.e. `plot` stays high if a request is pending.
- `clear_start` in the same cycle as a player req: clear wins. No ack is issued.
- `resetn` low has priority over `clear_start` and all requests.

## Test plan

- Reset, then a single clear: `clear_start` pulse.
  - Required: 19200 consecutive `plot` cycles.
  - First pixel (0,0), pixel 160 is (0,1), last pixel (159,119), all colour 000.
  - `clear_busy` high for exactly 19200 cycles.
- P1 only, `p1_req` held with (10,20,3'b100), updated after each ack.
  - Required: `plot` on alternating cycles.
  - First plot is 1 cycle after req, with x=10, y=20, colour=100.
  - `p2_ack` never asserts.
- Both players requesting continuously with P1=(5,5,001) and P2=(7,7,010).
  - Required: plots alternate P1, P2, P1, …, starting with P1 after reset.
  - Acks match the plotted source each cycle.
- Out of range: P2 requests (160,0,111).
  - Required: `p2_ack`=1, `plot`=0 that cycle, `oob`=1 and stays 1.
  - A following in-range request plots normally.
- Clear interaction:
  - Pulse `clear_start` at cycle 100 of a clear. Required: the next plot is (0,0) and the total clear runs 19200 more cycles.
  - Hold `p1_req` throughout. Required: no ack until after the last clear plot, then P1 is granted in the first idle cycle.
- Reset mid-clear at pixel 500.
  - Required: next cycle `plot`=0, `clear_busy`=0, all outputs zero.
  - No further clear plots.
